// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered NCH-channel, W-bit multiplexer with manual select and auto-scan.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   din          packed channels, channel c = din[c*W +: W]
//   mode         0 = manual (load/sel), 1 = scan (stepped every DWELL cycles)
//   sel, load    manual channel request and capture strobe
//   hold         scan: freeze channel advance and dwell count
//   dout         registered data of the current channel
//   dout_valid   dout holds valid data
//   ch_idx       channel dout was taken from
//   wrap         one-cycle pulse on the scan step back to a lower/equal channel
//   sel_err      one-cycle pulse on a rejected manual load
//
// Optional build macro MUX_CH_MASK_EN adds input ch_mask[NCH-1:0] (1 = channel
// enabled): scan skips disabled channels, loads to disabled channels are
// rejected, and an all-zero mask holds the channel with dout_valid low.
module mux_scan_reg #(
   parameter int unsigned NCH   = 16,
   parameter int unsigned W     = 1,
   parameter int unsigned SELW  = 4,
   parameter int unsigned DWELL = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH*W-1:0]    din,
   input  logic                mode,
   input  logic [SELW-1:0]     sel,
   input  logic                load,
   input  logic                hold,
`ifdef MUX_CH_MASK_EN
   input  logic [NCH-1:0]      ch_mask,
`endif
   output logic [W-1:0]        dout,
   output logic                dout_valid,
   output logic [SELW-1:0]     ch_idx,
   output logic                wrap,
   output logic                sel_err
);

   localparam int unsigned CNTW = $clog2(DWELL) + 1;

   // Reject configurations whose select width cannot address exactly NCH channels.
   generate
      if (SELW != $clog2(NCH)) begin : g_bad_selw
         $error("mux_scan_reg: SELW must equal clog2(NCH)");
      end
      if (DWELL < 1) begin : g_bad_dwell
         $error("mux_scan_reg: DWELL must be at least 1");
      end
   endgenerate

   logic [SELW-1:0] cur_ch_q,     cur_ch_d;
   logic [CNTW-1:0] dwell_cnt_q,  dwell_cnt_d;
   logic [W-1:0]    dout_q,       dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic [SELW-1:0] ch_idx_q,     ch_idx_d;
   logic            wrap_q,       wrap_d;
   logic            sel_err_q,    sel_err_d;

   logic [SELW-1:0] nxt_ch_c;     // channel the next scan step moves to
   logic            nxt_wrap_c;   // that step goes back to a lower/equal index
   logic            sel_ok_c;     // manual request is a legal, enabled channel
   logic            mask_any_c;   // at least one channel enabled

`ifdef MUX_CH_MASK_EN
   logic            nxt_found_c;
   int unsigned     cand_c;

   // Next enabled channel in ascending order with wraparound; the current
   // channel itself is the last candidate, so a single enabled channel wraps onto itself.
   always_comb begin
      nxt_ch_c    = cur_ch_q;
      nxt_found_c = 1'b0;
      cand_c      = 0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         cand_c = 32'(cur_ch_q) + k;
         if (cand_c >= NCH) cand_c = cand_c - NCH;
         if (!nxt_found_c && ch_mask[cand_c[SELW-1:0]]) begin
            nxt_found_c = 1'b1;
            nxt_ch_c    = cand_c[SELW-1:0];
         end
      end
      nxt_wrap_c = nxt_found_c && (nxt_ch_c <= cur_ch_q);
      mask_any_c = |ch_mask;
      sel_ok_c   = (32'(sel) < NCH) && ch_mask[sel];
   end
`else
   // Plain modulo-NCH step; every channel is enabled.
   always_comb begin
      nxt_wrap_c = (cur_ch_q == SELW'(NCH - 1));
      nxt_ch_c   = nxt_wrap_c ? '0 : cur_ch_q + SELW'(1);
      mask_any_c = 1'b1;
      sel_ok_c   = (32'(sel) < NCH);
   end
`endif

   // Channel selection, dwell counting and output capture.
   always_comb begin
      cur_ch_d     = cur_ch_q;
      dwell_cnt_d  = dwell_cnt_q;
      dout_d       = din[32'(cur_ch_q) * W +: W];
      dout_valid_d = mask_any_c;
      ch_idx_d     = cur_ch_q;
      wrap_d       = 1'b0;
      sel_err_d    = 1'b0;

      if (!mode) begin
         // Keeping the count cleared in manual mode gives a fresh full dwell on entry to scan.
         dwell_cnt_d = '0;
         if (load) begin
            if (sel_ok_c) cur_ch_d  = sel;
            else          sel_err_d = 1'b1;
         end
      end else if (!hold) begin
         if (dwell_cnt_q == CNTW'(DWELL - 1)) begin
            dwell_cnt_d = '0;
            cur_ch_d    = nxt_ch_c;
            wrap_d      = nxt_wrap_c;
         end else begin
            dwell_cnt_d = dwell_cnt_q + CNTW'(1);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_ch_q     <= '0;
         dwell_cnt_q  <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ch_idx_q     <= '0;
         wrap_q       <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         cur_ch_q     <= cur_ch_d;
         dwell_cnt_q  <= dwell_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ch_idx_q     <= ch_idx_d;
         wrap_q       <= wrap_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign ch_idx     = ch_idx_q;
   assign wrap       = wrap_q;
   assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: drives three mux_scan_reg instances (16ch/dwell 1, 16ch/dwell 3,
// 12ch/dwell 1) from shared stimulus and checks them against a cycle-level
// reference model, a directed vector table and hand-written corner sequences.
module tb_mux_scan_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] din;
   logic        mode, load, hold;
   logic [3:0]  sel;
   logic [15:0] mask;

   logic       a_dout, a_valid, a_wrap, a_err;
   logic [3:0] a_idx;
   logic       b_dout, b_valid, b_wrap, b_err;
   logic [3:0] b_idx;
   logic       c_dout, c_valid, c_wrap, c_err;
   logic [3:0] c_idx;

   mux_scan_reg #(.NCH(16), .W(1), .SELW(4), .DWELL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel), .load(load), .hold(hold),
`ifdef MUX_CH_MASK_EN
      .ch_mask(mask),
`endif
      .dout(a_dout), .dout_valid(a_valid), .ch_idx(a_idx), .wrap(a_wrap), .sel_err(a_err));

   mux_scan_reg #(.NCH(16), .W(1), .SELW(4), .DWELL(3)) u_b (
      .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel), .load(load), .hold(hold),
`ifdef MUX_CH_MASK_EN
      .ch_mask(mask),
`endif
      .dout(b_dout), .dout_valid(b_valid), .ch_idx(b_idx), .wrap(b_wrap), .sel_err(b_err));

   mux_scan_reg #(.NCH(12), .W(1), .SELW(4), .DWELL(1)) u_c (
      .clk(clk), .rst_n(rst_n), .din(din[11:0]), .mode(mode), .sel(sel), .load(load), .hold(hold),
`ifdef MUX_CH_MASK_EN
      .ch_mask(mask[11:0]),
`endif
      .dout(c_dout), .dout_valid(c_valid), .ch_idx(c_idx), .wrap(c_wrap), .sel_err(c_err));

   int n_cmp;
   int n_fail;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: channel, dwell position and last outputs held as plain integers.
   typedef struct {
      int cur;
      int cnt;
      int dout;
      int valid;
      int idx;
      int wrap;
      int err;
   } mst_t;

   function automatic mst_t mreset();
      mst_t r;
      r = '{default: 0};
      return r;
   endfunction

   function automatic mst_t mstep(input mst_t s, input int nch, input int dwell,
                                  input logic [15:0] d, input logic [15:0] m,
                                  input logic md, input logic ld, input logic hd,
                                  input logic [3:0] sl);
      mst_t        n;
      logic [15:0] en;
      int          nxt;
      bit          found;
      n       = s;
      en      = m & 16'((32'd1 << nch) - 1);
      n.dout  = int'(d[s.cur]);
      n.idx   = s.cur;
      n.valid = (en != 0) ? 1 : 0;
      n.wrap  = 0;
      n.err   = 0;
      nxt     = s.cur;
      found   = 0;
      if (!md) begin
         n.cnt = 0;
         if (ld) begin
            if (int'(sl) < nch && en[sl]) n.cur = int'(sl);
            else                          n.err = 1;
         end
      end else if (!hd) begin
         if (s.cnt == dwell - 1) begin
            n.cnt = 0;
            for (int k = 1; k <= nch; k++) begin
               if (!found && en[(s.cur + k) % nch]) begin
                  found = 1;
                  nxt   = (s.cur + k) % nch;
               end
            end
            if (found) begin
               n.wrap = (nxt <= s.cur) ? 1 : 0;
               n.cur  = nxt;
            end
         end else begin
            n.cnt = s.cnt + 1;
         end
      end
      return n;
   endfunction

   mst_t ma, mb, mc;
   bit   chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         ma     <= mreset();
         mb     <= mreset();
         mc     <= mreset();
         chk_en <= 1'b1;
      end else begin
         ma <= mstep(ma, 16, 1, din, mask, mode, load, hold, sel);
         mb <= mstep(mb, 16, 3, din, mask, mode, load, hold, sel);
         mc <= mstep(mc, 12, 1, din, mask, mode, load, hold, sel);
      end
   end

   // Every cycle after the first reset edge, all instances must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("a_dout", a_dout, ma.dout);   check("a_valid", a_valid, ma.valid);
         check("a_idx", a_idx, ma.idx);      check("a_wrap", a_wrap, ma.wrap);
         check("a_err", a_err, ma.err);
         check("b_dout", b_dout, mb.dout);   check("b_valid", b_valid, mb.valid);
         check("b_idx", b_idx, mb.idx);      check("b_wrap", b_wrap, mb.wrap);
         check("b_err", b_err, mb.err);
         check("c_dout", c_dout, mc.dout);   check("c_valid", c_valid, mc.valid);
         check("c_idx", c_idx, mc.idx);      check("c_wrap", c_wrap, mc.wrap);
         check("c_err", c_err, mc.err);
      end
   end

   // Directed vectors for instance a: inputs for one cycle and outputs after that edge.
   typedef struct {
      logic       r, md, ld, hd;
      logic [3:0] s;
      logic       ed, ev;
      logic [3:0] ei;
      logic       ew, ee;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic md, input logic ld, input logic hd,
                               input logic [3:0] s, input logic ed, input logic ev,
                               input logic [3:0] ei, input logic ew, input logic ee);
      vec_t v;
      v.r = r; v.md = md; v.ld = ld; v.hd = hd; v.s = s;
      v.ed = ed; v.ev = ev; v.ei = ei; v.ew = ew; v.ee = ee;
      return v;
   endfunction

   task automatic step(input logic r, input logic md, input logic ld, input logic hd,
                       input logic [3:0] s);
      rst_n = r; mode = md; load = ld; hold = hd; sel = s;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   logic scan_exp [16];

   initial begin
      n_cmp = 0; n_fail = 0;
      rst_n = 1'b0; din = 16'h5441; mode = 1'b0; load = 1'b0; hold = 1'b0; sel = 4'd0;
      mask = 16'hFFFF;
      scan_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset for three edges, then manual loads of 6, 7, 12.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  1, 1, 4'd0,  0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 4'd6,  1, 1, 4'd0,  0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  1, 1, 4'd6,  0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 4'd7,  1, 1, 4'd6,  0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  0, 1, 4'd7,  0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 4'd12, 0, 1, 4'd7,  0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  1, 1, 4'd12, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 4'd0,  1, 1, 4'd12, 0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 4'd0,  1, 1, 4'd12, 0, 0));
      // Scan from channel 0 through a full wrap.
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk(1, 1, 0, 0, 4'd0, scan_exp[k], 1, 4'(k), (k == 15), 0));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(1, 1, 0, 0, 4'd0, scan_exp[k], 1, 4'(k), 0, 0));
      // Hold on channel 10 for five cycles, then finish its dwell and step on.
      for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 1, 0, 1, 4'd0, 1, 1, 4'd10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'd0,  1, 1, 4'd10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 4'd0,  0, 1, 4'd11, 0, 0));
      // A load while scanning is ignored.
      tbl.push_back(mk(1, 1, 1, 0, 4'd3,  1, 1, 4'd12, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].md, tbl[i].ld, tbl[i].hd, tbl[i].s);
         check($sformatf("tbl%0d_dout", i), a_dout, tbl[i].ed);
         check($sformatf("tbl%0d_valid", i), a_valid, tbl[i].ev);
         check($sformatf("tbl%0d_idx", i), a_idx, tbl[i].ei);
         check($sformatf("tbl%0d_wrap", i), a_wrap, tbl[i].ew);
         check($sformatf("tbl%0d_err", i), a_err, tbl[i].ee);
      end

      // DWELL=3: each channel appears for exactly three consecutive outputs.
      step(0, 1, 0, 0, 4'd0);
      for (int k = 0; k < 12; k++) begin
         step(1, 1, 0, 0, 4'd0);
         check("b_dwell_idx", b_idx, 32'(k / 3));
      end

      // 12-channel instance: out-of-range load rejected for one cycle only.
      step(0, 0, 0, 0, 4'd0);
      step(1, 0, 1, 0, 4'd13);
      check("c_bad_err", c_err, 1);
      check("c_bad_idx", c_idx, 0);
      step(1, 0, 0, 0, 4'd0);
      check("c_bad_err_clr", c_err, 0);
      check("c_bad_idx_keep", c_idx, 0);
      step(1, 1, 1, 0, 4'd13);
      check("c_scan_load_err", c_err, 0);

      // Reset in the middle of a scan at channel 9.
      step(0, 1, 0, 0, 4'd0);
      for (int g = 0; g < 40 && a_idx != 4'd9; g++) step(1, 1, 0, 0, 4'd0);
      check("reach_ch9", a_idx, 9);
      step(0, 1, 0, 0, 4'd0);
      check("mid_rst_dout", a_dout, 0);
      check("mid_rst_valid", a_valid, 0);
      check("mid_rst_idx", a_idx, 0);
      check("mid_rst_wrap", a_wrap, 0);
      check("mid_rst_err", a_err, 0);
      step(1, 1, 0, 0, 4'd0);
      check("resume_idx0", a_idx, 0);
      check("resume_valid", a_valid, 1);
      step(1, 1, 0, 0, 4'd0);
      check("resume_idx1", a_idx, 1);

`ifdef MUX_CH_MASK_EN
      // Only channels 0 and 2 enabled: 0,2,0,2 with wrap on every 2->0 step.
      mask = 16'h0005;
      step(0, 1, 0, 0, 4'd0);
      for (int k = 0; k < 8; k++) begin
         step(1, 1, 0, 0, 4'd0);
         check("mask_idx", a_idx, (k % 2 == 1) ? 2 : 0);
         check("mask_wrap", a_wrap, 32'(k % 2));
      end
      step(1, 0, 1, 0, 4'd1);
      check("mask_load_err", a_err, 1);
      mask = 16'h0000;
      step(1, 1, 0, 0, 4'd0);
      check("mask_zero_valid", a_valid, 0);
      mask = 16'hFFFF;
`endif

      // Randomised traffic; the per-cycle model comparison does the checking.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         load = ($urandom_range(0, 2) == 0);
         hold = ($urandom_range(0, 3) == 0);
         sel  = 4'($urandom_range(0, 15));
         din  = 16'($urandom);
`ifdef MUX_CH_MASK_EN
         case ($urandom_range(0, 9))
            0:       mask = 16'h0000;
            1, 2:    mask = 16'($urandom);
            3:       mask = 16'hFFFF;
            default: ;
         endcase
`endif
         @(posedge clk);
         #1;
      end

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
